// File: rtl/ahb_slave_arbiter.sv
// ahb_slave_arbiter
//   Per-slave AHB arbiter. Masters that decode an access to this slave raise
//   their req bit; the arbiter grants one of them round-robin and keeps it as
//   owner until its burst ends. Then it re-arbitrates on the same edge, so
//   back-to-back owners see no idle cycle. Every register advances only on
//   an edge with hready=1.
//
//   Optional feature (compile-time macro AHB_ARB_LOCK_EN):
//     adds input hmastlock_in. While it is high, the current owner is never
//     released.
//
// Ports
//   HCLK          clock, rising edge
//   HRESETn       asynchronous active-low reset
//   req           per-master access request to this slave
//   htrans_in     HTRANS of the selected master (slave mux output)
//   hburst_in     HBURST of the selected master
//   hready        HREADYOUT of this slave
//   hmastlock_in  (AHB_ARB_LOCK_EN only) locked-transfer indication
//   sel_addr      one-hot/zero address-phase select (slave mux sel)
//   sel_data      one-hot/zero data-phase select (response routing)
//   busy          high while a master owns the slave
module ahb_slave_arbiter #(
  parameter int CHANNEL_NUM = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [CHANNEL_NUM-1:0] req,
  input  logic [1:0]             htrans_in,
  input  logic [2:0]             hburst_in,
  input  logic                   hready,
`ifdef AHB_ARB_LOCK_EN
  input  logic                   hmastlock_in,
`endif
  output logic [CHANNEL_NUM-1:0] sel_addr,
  output logic [CHANNEL_NUM-1:0] sel_data,
  output logic                   busy
);

  localparam int PW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_WRAP4  = 3'b010;
  localparam logic [2:0] HB_INCR4  = 3'b011;
  localparam logic [2:0] HB_WRAP8  = 3'b100;
  localparam logic [2:0] HB_INCR8  = 3'b101;
  localparam logic [2:0] HB_WRAP16 = 3'b110;
  localparam logic [2:0] HB_INCR16 = 3'b111;

  typedef enum logic {IDLE, OWN} state_t;

  state_t                   state;
  logic [PW-1:0]            rr_ptr;
  logic [3:0]               beat_cnt;

  logic [2*CHANNEL_NUM-1:0] req_dbl;
  logic [CHANNEL_NUM-1:0]   req_rot;
  logic                     win_vld;
  logic [PW-1:0]            win_off;
  logic [PW:0]              win_sum;
  logic [PW-1:0]            win_idx;
  logic [PW-1:0]            nxt_ptr;
  logic [CHANNEL_NUM-1:0]   win_oh;
  logic [3:0]               beat_nxt;
  logic                     release_own;

  // Rotate req so that bit rr_ptr lands at bit 0. The lowest set bit of
  // the rotated vector is then the round-robin winner's offset from rr_ptr.
  assign req_dbl = {req, req} >> rr_ptr;
  assign req_rot = req_dbl[CHANNEL_NUM-1:0];

  always_comb begin
    win_vld = 1'b0;
    win_off = '0;
    for (int i = CHANNEL_NUM-1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_vld = 1'b1;
        win_off = PW'(i);
      end
    end
  end

  assign win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
  assign win_idx = (win_sum >= (PW+1)'(CHANNEL_NUM)) ?
                   PW'(win_sum - (PW+1)'(CHANNEL_NUM)) : win_sum[PW-1:0];
  assign nxt_ptr = (win_idx == PW'(CHANNEL_NUM-1)) ? '0 : win_idx + PW'(1);

  // Per-channel one-hot decode of the winner.
  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_oh
    assign win_oh[g] = win_vld && (win_idx == PW'(g));
  end

  // The beat counter holds the number of SEQ beats still to come in a
  // fixed-length burst. INCR/SINGLE load 0, so they never end on a count.
  always_comb begin
    beat_nxt = beat_cnt;
    if (htrans_in == HT_NONSEQ) begin
      case (hburst_in)
        HB_WRAP4,  HB_INCR4:  beat_nxt = 4'd3;
        HB_WRAP8,  HB_INCR8:  beat_nxt = 4'd7;
        HB_WRAP16, HB_INCR16: beat_nxt = 4'd15;
        default:              beat_nxt = 4'd0;
      endcase
    end else if (htrans_in == HT_SEQ && beat_cnt != 4'd0) begin
      beat_nxt = beat_cnt - 4'd1;
    end
  end

  // Ownership ends on an IDLE transfer, a SINGLE, or the last fixed beat.
  // Every other case holds: BUSY, INCR, and mid-burst SEQ.
  always_comb begin
    release_own = (htrans_in == HT_IDLE) ||
                  (htrans_in == HT_NONSEQ && hburst_in == HB_SINGLE) ||
                  (htrans_in == HT_SEQ && beat_cnt == 4'd1);
`ifdef AHB_ARB_LOCK_EN
    if (hmastlock_in) release_own = 1'b0;
`endif
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      sel_addr <= '0;
      sel_data <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (hready) begin
      beat_cnt <= beat_nxt;
      // The data phase follows the accepted address phase. Only NONSEQ/SEQ
      // carry a data phase.
      sel_data <= htrans_in[1] ? sel_addr : '0;
      if (state == IDLE || release_own) begin
        if (win_vld) begin
          state    <= OWN;
          sel_addr <= win_oh;
          busy     <= 1'b1;
          rr_ptr   <= nxt_ptr;
        end else begin
          state    <= IDLE;
          sel_addr <= '0;
          busy     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Testbench for ahb_slave_arbiter (CHANNEL_NUM=2). It has directed scenarios
// with hand-computed expectations, then randomized traffic. A behavioural
// model is checked against the DUT on every falling clock edge.
module tb_ahb_slave_arbiter;
  localparam int N = 2;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000, B_INCR = 3'b001, B_INCR4 = 3'b011, B_INCR8 = 3'b101;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic [N-1:0] req = '0;
  logic [1:0]   htrans_in = 2'b00;
  logic [2:0]   hburst_in = 3'b000;
  logic         hready = 1'b1;
`ifdef AHB_ARB_LOCK_EN
  logic         hmastlock_in = 1'b0;
`endif
  logic [N-1:0] sel_addr, sel_data;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  ahb_slave_arbiter #(.CHANNEL_NUM(N)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .htrans_in(htrans_in),
    .hburst_in(hburst_in), .hready(hready),
`ifdef AHB_ARB_LOCK_EN
    .hmastlock_in(hmastlock_in),
`endif
    .sel_addr(sel_addr), .sel_data(sel_data), .busy(busy));

  always #5 HCLK = ~HCLK;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: owner index (-1 = none), round-robin pointer, and
  // the number of SEQ beats still owed by the current fixed-length burst.
  int           m_owner = -1;
  int           m_ptr = 0;
  int           m_left = 0;
  logic [N-1:0] m_data = '0;
  logic [N-1:0] m_nd;
  bit           m_rel;

  function automatic logic [N-1:0] oh(input int o);
    logic [N-1:0] v;
    v = '0;
    if (o >= 0) v[o] = 1'b1;
    return v;
  endfunction

  function automatic int burst_beats(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  task automatic m_grant();
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req[k]) begin
        m_owner = k;
        m_ptr = (k + 1) % N;
        return;
      end
    end
    m_owner = -1;
  endtask

  initial forever begin
    @(posedge HCLK or negedge HRESETn);
    if (!HRESETn) begin
      m_owner = -1; m_ptr = 0; m_left = 0; m_data = '0;
    end else if (hready) begin
      m_nd = htrans_in[1] ? oh(m_owner) : '0;
      m_rel = (m_owner < 0) || (htrans_in == T_IDLE) ||
              (htrans_in == T_NSEQ && hburst_in == B_SINGLE) ||
              (htrans_in == T_SEQ && m_left == 1);
`ifdef AHB_ARB_LOCK_EN
      if (m_owner >= 0 && hmastlock_in) m_rel = 0;
`endif
      if (htrans_in == T_NSEQ) m_left = burst_beats(hburst_in) - 1;
      else if (htrans_in == T_SEQ && m_left > 0) m_left = m_left - 1;
      if (m_rel) m_grant();
      m_data = m_nd;
    end
  end

  initial forever begin
    @(negedge HCLK);
    cmp("model_sel_addr", sel_addr, oh(m_owner));
    cmp("model_sel_data", sel_data, m_data);
    cmp("model_busy", busy, m_owner >= 0);
    cmp("onehot", ($countones(sel_addr) <= 1) && ($countones(sel_data) <= 1), 1);
  end

  task automatic cyc(input logic [N-1:0] r, input logic [1:0] t, input logic [2:0] b, input logic rdy);
    #2;
    req = r; htrans_in = t; hburst_in = b; hready = rdy;
    @(negedge HCLK);
  endtask

  task automatic lit(input string name, input logic [N-1:0] a, input logic [N-1:0] d, input logic bz);
    cmp({name, "_addr"}, sel_addr, a);
    cmp({name, "_data"}, sel_data, d);
    cmp({name, "_busy"}, busy, bz);
  endtask

  initial begin
    @(negedge HCLK);
    lit("reset", 2'b00, 2'b00, 1'b0);
    #2 HRESETn = 1'b1;
    @(negedge HCLK);
    lit("post_reset", 2'b00, 2'b00, 1'b0);

    // Two requesters; master 0 single then master 1 with no gap
    cyc(2'b11, T_IDLE, B_SINGLE, 1); lit("a_grant",   2'b01, 2'b00, 1);
    cyc(2'b11, T_NSEQ, B_SINGLE, 1); lit("a_switch",  2'b10, 2'b01, 1);
    cyc(2'b00, T_NSEQ, B_SINGLE, 1); lit("a_release", 2'b00, 2'b10, 0);
    cyc(2'b00, T_IDLE, B_SINGLE, 1); lit("a_idle",    2'b00, 2'b00, 0);

    // INCR4 from master 0 with master 1 waiting
    cyc(2'b11, T_IDLE, B_SINGLE, 1); lit("b_grant", 2'b01, 2'b00, 1);
    cyc(2'b11, T_NSEQ, B_INCR4, 1);  lit("b_beat1", 2'b01, 2'b01, 1);
    cyc(2'b11, T_SEQ,  B_INCR4, 1);  lit("b_beat2", 2'b01, 2'b01, 1);
    cyc(2'b11, T_SEQ,  B_INCR4, 1);  lit("b_beat3", 2'b01, 2'b01, 1);
    cyc(2'b11, T_SEQ,  B_INCR4, 1);  lit("b_beat4", 2'b10, 2'b01, 1);

    // Master 1 INCR4 stalled on its last beat for 3 cycles
    cyc(2'b10, T_NSEQ, B_INCR4, 1);  lit("c_beat1", 2'b10, 2'b10, 1);
    cyc(2'b11, T_SEQ,  B_INCR4, 1);  lit("c_beat2", 2'b10, 2'b10, 1);
    cyc(2'b11, T_SEQ,  B_INCR4, 1);  lit("c_beat3", 2'b10, 2'b10, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, T_SEQ, B_INCR4, 0); lit("c_stall", 2'b10, 2'b10, 1);
    end
    cyc(2'b11, T_SEQ, B_INCR4, 1);   lit("c_done", 2'b01, 2'b10, 1);

    // INCR with BUSY beats, ended by IDLE
    cyc(2'b11, T_NSEQ, B_INCR, 1); lit("d_nseq",  2'b01, 2'b01, 1);
    cyc(2'b11, T_BUSY, B_INCR, 1); lit("d_busy1", 2'b01, 2'b00, 1);
    cyc(2'b11, T_SEQ,  B_INCR, 1); lit("d_seq",   2'b01, 2'b01, 1);
    cyc(2'b11, T_BUSY, B_INCR, 1); lit("d_busy2", 2'b01, 2'b00, 1);
    cyc(2'b00, T_IDLE, B_INCR, 1); lit("d_rel",   2'b00, 2'b00, 0);

    // Asynchronous reset in the middle of an INCR8
    cyc(2'b01, T_IDLE, B_SINGLE, 1); lit("e_grant", 2'b01, 2'b00, 1);
    cyc(2'b01, T_NSEQ, B_INCR8, 1);  lit("e_beat1", 2'b01, 2'b01, 1);
    cyc(2'b01, T_SEQ,  B_INCR8, 1);  lit("e_beat2", 2'b01, 2'b01, 1);
    #2 HRESETn = 1'b0; req = 2'b10; htrans_in = T_IDLE;
    #1 lit("e_async", 2'b00, 2'b00, 0);
    @(negedge HCLK);
    #2 HRESETn = 1'b1;
    @(negedge HCLK);
    lit("e_regrant", 2'b10, 2'b00, 1);

`ifdef AHB_ARB_LOCK_EN
    cyc(2'b11, T_NSEQ, B_SINGLE, 1); lit("f_own0", 2'b01, 2'b10, 1);
    hmastlock_in = 1'b1;
    cyc(2'b11, T_NSEQ, B_SINGLE, 1); lit("f_lock1", 2'b01, 2'b01, 1);
    cyc(2'b11, T_NSEQ, B_SINGLE, 1); lit("f_lock2", 2'b01, 2'b01, 1);
    hmastlock_in = 1'b0;
    cyc(2'b11, T_NSEQ, B_SINGLE, 1); lit("f_unlock", 2'b10, 2'b01, 1);
`endif

    // Randomized traffic, checked by the model on every cycle
    for (int i = 0; i < 3000; i++) begin
      int r;
      #2;
      HRESETn = ($urandom_range(0, 149) != 0);
      req = N'($urandom);
      r = $urandom_range(0, 9);
      htrans_in = (r < 2) ? T_IDLE : (r == 2) ? T_BUSY : (r < 6) ? T_NSEQ : T_SEQ;
      hburst_in = 3'($urandom_range(0, 7));
      hready = ($urandom_range(0, 3) != 0);
`ifdef AHB_ARB_LOCK_EN
      hmastlock_in = ($urandom_range(0, 3) == 0);
`endif
      @(negedge HCLK);
    end

    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
